uart_image_loader: RTL and testbench

Frame assembler that consumes the byte stream from the RS-232 receiver and writes one MNIST image (28x28 8-bit pixels) into the accelerator's pixel memory. It detects each new received byte, hunts for a sync byte, streams pixel bytes to a memory write port and verifies a trailing checksum. It then holds `img_valid` until the inference core acknowledges. It sits between `rs232` (`rxdata`/`rxdata_rdy`) and the pixel RAM / inference controller.

---
 rtl/uart_image_loader.sv | 143 ++++++++++++++
 tb/tb_uart_image_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_image_loader.sv
// Assembles one SYNC-framed image from the receiver byte stream into pixel memory.
// The trailing checksum is verified, and img_valid is then held until img_ack.
module uart_image_loader #(
  parameter int unsigned NPIX      = 784,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter int unsigned TO_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxdata,
  input  logic              rxdata_rdy,
  input  logic              img_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              img_valid,
  output logic              pkt_err,
  output logic              busy
);

  localparam int unsigned TO_W = $clog2(TO_CYCLES) + 1;

  typedef enum logic [1:0] {HUNT, PIXELS, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              sync1, sync2, sync3;
  logic [7:0]        byte_q;
  logic              byte_stb;
  logic              mem_we_d, pkt_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              timeout;

  // rxdata_rdy crosses from the baud domain; byte_q is captured on the edge that raises byte_stb
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      sync1 <= rxdata_rdy;
      sync2 <= sync1;
      sync3 <= sync2;
      if (sync1 && !sync2) byte_q <= rxdata;
    end
  end

  assign byte_stb = sync2 & ~sync3;
  assign timeout  = (to_cnt_q == TO_W'(TO_CYCLES - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      sum_q     <= 8'h00;
      to_cnt_q  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      img_valid <= 1'b0;
      pkt_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      to_cnt_q  <= to_cnt_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      img_valid <= (state_d == DONE);
      pkt_err   <= pkt_err_d;
      busy      <= (state_q == PIXELS) || (state_q == CHECK);
    end
  end

  // Next-state and output decode; a byte strobe always wins over a same-cycle timeout
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    to_cnt_d    = to_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    pkt_err_d   = 1'b0;
    case (state_q)
      HUNT: begin
        if (byte_stb && (byte_q == SYNC)) begin
          state_d  = PIXELS;
          idx_d    = '0;
          sum_d    = 8'h00;
          to_cnt_d = '0;
        end
      end
      PIXELS: begin
        if (byte_stb) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = byte_q;
          sum_d       = sum_q + byte_q;
          idx_d       = idx_q + ADDR_W'(1);
          to_cnt_d    = '0;
          if (idx_q == ADDR_W'(NPIX - 1)) state_d = CHECK;
        end else if (timeout) begin
          pkt_err_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = HUNT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      CHECK: begin
        if (byte_stb) begin
          to_cnt_d = '0;
          if (byte_q == sum_q) begin
            state_d = DONE;
          end else begin
            pkt_err_d = 1'b1;
            state_d   = HUNT;
          end
        end else if (timeout) begin
          pkt_err_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = HUNT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DONE: begin
        if (img_ack) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader: framing, checksum, hunting, timeout,
// mid-frame reset and overrun/ack, with every memory write checked against p[i]=i mod 256.
module tb_uart_image_loader;

  localparam int unsigned NPIX      = 784;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned TO_CYCLES = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rxdata;
  logic              rxdata_rdy;
  logic              img_ack;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              img_valid;
  logic              pkt_err;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int wr_total = 0;
  int err_total = 0;
  int wr_base  = 0;
  int err_base = 0;
  logic [7:0] good_ck;

  uart_image_loader #(
    .NPIX(NPIX), .ADDR_W(ADDR_W), .SYNC(8'hA5), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .rxdata(rxdata), .rxdata_rdy(rxdata_rdy), .img_ack(img_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .img_valid(img_valid), .pkt_err(pkt_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write and error monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we) begin
      check("wr_addr", 32'(mem_addr), 32'(wr_total - wr_base));
      check("wr_data", 32'(mem_wdata), 32'((wr_total - wr_base) % 256));
      wr_total++;
    end
    if (pkt_err) err_total++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One byte per 16 clk cycles: rdy high 8, low 8
  task automatic send_byte(input logic [7:0] b);
    rxdata     = b;
    rxdata_rdy = 1'b1;
    cycles(8);
    rxdata_rdy = 1'b0;
    cycles(8);
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) send_byte(8'(i));
  endtask

  task automatic send_frame(input logic [7:0] ck);
    wr_base  = wr_total;
    err_base = err_total;
    send_byte(8'hA5);
    send_pixels(NPIX);
    send_byte(ck);
    cycles(4);
  endtask

  task automatic ack_image();
    check("valid_pre_ack", 32'(img_valid), 32'd1);
    img_ack = 1'b1;
    cycles(1);
    img_ack = 1'b0;
    check("valid_post_ack", 32'(img_valid), 32'd0);
  endtask

  initial begin
    int s;
    logic [7:0] v;
    s = 0;
    for (int i = 0; i < int'(NPIX); i++) s = (s + i) % 256;
    good_ck = 8'(s);

    rst = 1'b0; rxdata = 8'h00; rxdata_rdy = 1'b0; img_ack = 1'b0;
    cycles(3);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_img_valid", 32'(img_valid), 32'd0);
    check("rst_pkt_err", 32'(pkt_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    cycles(2);

    // Good frame
    send_frame(good_ck);
    check("good_writes", 32'(wr_total - wr_base), 32'(NPIX));
    check("good_err", 32'(err_total - err_base), 32'd0);
    check("good_valid", 32'(img_valid), 32'd1);
    check("good_busy", 32'(busy), 32'd0);

    // Overrun in DONE, then ack
    for (int i = 0; i < 10; i++) send_byte((i == 0) ? 8'hA5 : 8'(i));
    check("overrun_writes", 32'(wr_total - wr_base), 32'(NPIX));
    ack_image();
    cycles(2);

    // Bad checksum
    send_frame(good_ck + 8'd1);
    check("bad_writes", 32'(wr_total - wr_base), 32'(NPIX));
    check("bad_err", 32'(err_total - err_base), 32'd1);
    check("bad_valid", 32'(img_valid), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);

    // Hunting past non-SYNC bytes
    wr_base = wr_total;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("hunt_no_writes", 32'(wr_total - wr_base), 32'd0);
    check("hunt_busy", 32'(busy), 32'd0);
    send_frame(good_ck);
    check("hunt_writes", 32'(wr_total - wr_base), 32'(NPIX));
    check("hunt_err", 32'(err_total - err_base), 32'd0);
    ack_image();
    cycles(2);

    // Timeout after 100 pixels
    wr_base  = wr_total;
    err_base = err_total;
    send_byte(8'hA5);
    send_pixels(100);
    check("to_writes", 32'(wr_total - wr_base), 32'd100);
    check("to_busy_mid", 32'(busy), 32'd1);
    check("to_no_err_yet", 32'(err_total - err_base), 32'd0);
    cycles(TO_CYCLES + 100);
    check("to_err", 32'(err_total - err_base), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_valid", 32'(img_valid), 32'd0);

    // Restart from address 0, then reset after 300 pixels
    wr_base  = wr_total;
    err_base = err_total;
    send_byte(8'hA5);
    send_pixels(300);
    check("rf_writes", 32'(wr_total - wr_base), 32'd300);
    check("rf_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    check("rf_mem_we", 32'(mem_we), 32'd0);
    check("rf_mem_addr", 32'(mem_addr), 32'd0);
    check("rf_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rf_img_valid", 32'(img_valid), 32'd0);
    check("rf_pkt_err", 32'(pkt_err), 32'd0);
    check("rf_busy_rst", 32'(busy), 32'd0);
    wr_base = wr_total;
    for (int k = 300; k < int'(NPIX); k++) begin
      v = 8'(k);
      send_byte((v == 8'hA5) ? 8'h5A : v);
    end
    check("rf_ignored", 32'(wr_total - wr_base), 32'd0);
    check("rf_busy_after", 32'(busy), 32'd0);
    send_frame(good_ck);
    check("rf_frame_writes", 32'(wr_total - wr_base), 32'(NPIX));
    check("rf_frame_err", 32'(err_total - err_base), 32'd0);
    ack_image();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
